// File: rtl/pwr_seq_ctrl.sv
// pwr_seq_ctrl: board power-sequencing controller.
// Brings up P1V8 -> P3V3 -> P1V1 after VCORE is good, then releases the
// PCIe/PHY resets and CPU POR. It watches power-goods for timeouts and loss,
// shuts down in reverse order and latches a fault code for the BMC.
// Build option: define PWR_SEQ_SOFT_POR_EN to release pcie_rst_n/phy_rst_n
// DLY_RST_MS after P1V1 good. Without it they track cpu_por_n.
module pwr_seq_ctrl #(
    parameter int CNT_W         = 11,
    parameter int DLY_STEP_MS   = 6,
    parameter int DLY_RST_MS    = 10,
    parameter int DLY_POR_MS    = 400,
    parameter int PG_TIMEOUT_MS = 100
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       ms_pulse,
    input  logic       vcore_en,
    input  logic       vcore_pwrgd,
    input  logic       p1v8_pwrgd,
    input  logic       p3v3_pwrgd,
    input  logic       p1v1_pwrgd,
    output logic       p1v8_en,
    output logic       p3v3_en,
    output logic       p1v1_en,
    output logic       pcie_rst_n,
    output logic       phy_rst_n,
    output logic       cpu_por_n,
    output logic [3:0] seq_state,
    output logic       fault,
    output logic [2:0] fault_code
);

    localparam logic [3:0] ST_OFF       = 4'd0;
    localparam logic [3:0] ST_VCORE_DLY = 4'd1;
    localparam logic [3:0] ST_WAIT_1V8  = 4'd2;
    localparam logic [3:0] ST_DLY_1V8   = 4'd3;
    localparam logic [3:0] ST_WAIT_3V3  = 4'd4;
    localparam logic [3:0] ST_DLY_3V3   = 4'd5;
    localparam logic [3:0] ST_WAIT_1V1  = 4'd6;
    localparam logic [3:0] ST_RST_DLY   = 4'd7;
    localparam logic [3:0] ST_ON        = 4'd8;
    localparam logic [3:0] ST_SHDN_3V3  = 4'd9;
    localparam logic [3:0] ST_SHDN_1V8  = 4'd10;
    localparam logic [3:0] ST_FAULT     = 4'd15;

    localparam logic [2:0] FC_1V8_TIMEOUT = 3'd1;
    localparam logic [2:0] FC_3V3_TIMEOUT = 3'd2;
    localparam logic [2:0] FC_1V1_TIMEOUT = 3'd3;
    localparam logic [2:0] FC_PG_LOSS     = 3'd4;
    localparam logic [2:0] FC_VCORE_LOSS  = 3'd5;

    localparam logic [CNT_W-1:0] STEP_CNT    = CNT_W'(DLY_STEP_MS);
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(PG_TIMEOUT_MS);
    localparam logic [CNT_W-1:0] POR_CNT     = CNT_W'(DLY_POR_MS);

    // The POR release must not precede the PCIe/PHY release; an empty marker
    // block appears in the elaborated hierarchy if the parameters disagree.
    if (DLY_POR_MS < DLY_RST_MS) begin : g_dly_por_before_rst
    end

    logic [3:0]       state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             p1v8_en_reg, p1v8_en_next;
    logic             p3v3_en_reg, p3v3_en_next;
    logic             p1v1_en_reg, p1v1_en_next;
    logic             cpu_por_reg, cpu_por_next;
    logic             fault_reg, fault_next;
    logic [2:0]       fault_code_reg, fault_code_next;
`ifdef PWR_SEQ_SOFT_POR_EN
    localparam logic [CNT_W-1:0] RST_CNT = CNT_W'(DLY_RST_MS);
    // Shared release for the PCIe and PHY resets.
    logic             io_rst_reg, io_rst_next;
`endif
    logic             in_seq;
    logic             pg_loss;
    logic             fault_hit;
    logic [2:0]       fault_cause;

    // Next-state, output and counter logic for the sequencer.
    always_comb begin
        state_next      = state_reg;
        p1v8_en_next    = p1v8_en_reg;
        p3v3_en_next    = p3v3_en_reg;
        p1v1_en_next    = p1v1_en_reg;
        cpu_por_next    = cpu_por_reg;
        fault_next      = fault_reg;
        fault_code_next = fault_code_reg;
`ifdef PWR_SEQ_SOFT_POR_EN
        io_rst_next     = io_rst_reg;
`endif
        fault_hit       = 1'b0;
        fault_cause     = 3'd0;

        in_seq  = (state_reg >= ST_VCORE_DLY) && (state_reg <= ST_ON);
        // A rail is only expected to be good once its own WAIT state is left.
        pg_loss = (p1v8_en_reg && !p1v8_pwrgd && (state_reg != ST_WAIT_1V8)) ||
                  (p3v3_en_reg && !p3v3_pwrgd && (state_reg != ST_WAIT_3V3)) ||
                  (p1v1_en_reg && !p1v1_pwrgd && (state_reg != ST_WAIT_1V1));

        if (in_seq && !vcore_en) begin
            // Orderly off: resets and P1V1 drop now, remaining rails unwind.
            p1v1_en_next = 1'b0;
            cpu_por_next = 1'b0;
`ifdef PWR_SEQ_SOFT_POR_EN
            io_rst_next  = 1'b0;
`endif
            if (p3v3_en_reg)
                state_next = ST_SHDN_3V3;
            else if (p1v8_en_reg)
                state_next = ST_SHDN_1V8;
            else
                state_next = ST_OFF;
        end else if (in_seq && !vcore_pwrgd) begin
            fault_hit   = 1'b1;
            fault_cause = FC_VCORE_LOSS;
        end else if (in_seq && pg_loss) begin
            fault_hit   = 1'b1;
            fault_cause = FC_PG_LOSS;
        end else begin
            case (state_reg)
                ST_OFF: begin
                    if (vcore_en && vcore_pwrgd)
                        state_next = ST_VCORE_DLY;
                end
                ST_VCORE_DLY: begin
                    if (cnt_reg == STEP_CNT) begin
                        p1v8_en_next = 1'b1;
                        state_next   = ST_WAIT_1V8;
                    end
                end
                ST_WAIT_1V8: begin
                    if (p1v8_pwrgd) begin
                        state_next = ST_DLY_1V8;
                    end else if (cnt_reg == TIMEOUT_CNT) begin
                        fault_hit   = 1'b1;
                        fault_cause = FC_1V8_TIMEOUT;
                    end
                end
                ST_DLY_1V8: begin
                    if (cnt_reg == STEP_CNT) begin
                        p3v3_en_next = 1'b1;
                        state_next   = ST_WAIT_3V3;
                    end
                end
                ST_WAIT_3V3: begin
                    if (p3v3_pwrgd) begin
                        state_next = ST_DLY_3V3;
                    end else if (cnt_reg == TIMEOUT_CNT) begin
                        fault_hit   = 1'b1;
                        fault_cause = FC_3V3_TIMEOUT;
                    end
                end
                ST_DLY_3V3: begin
                    if (cnt_reg == STEP_CNT) begin
                        p1v1_en_next = 1'b1;
                        state_next   = ST_WAIT_1V1;
                    end
                end
                ST_WAIT_1V1: begin
                    if (p1v1_pwrgd) begin
                        state_next = ST_RST_DLY;
                    end else if (cnt_reg == TIMEOUT_CNT) begin
                        fault_hit   = 1'b1;
                        fault_cause = FC_1V1_TIMEOUT;
                    end
                end
                ST_RST_DLY: begin
`ifdef PWR_SEQ_SOFT_POR_EN
                    if (cnt_reg == RST_CNT)
                        io_rst_next = 1'b1;
`endif
                    if (cnt_reg == POR_CNT) begin
                        cpu_por_next = 1'b1;
                        state_next   = ST_ON;
                    end
                end
                ST_ON: begin
                end
                ST_SHDN_3V3: begin
                    if (cnt_reg == STEP_CNT) begin
                        p3v3_en_next = 1'b0;
                        state_next   = ST_SHDN_1V8;
                    end
                end
                ST_SHDN_1V8: begin
                    if (cnt_reg == STEP_CNT) begin
                        p1v8_en_next = 1'b0;
                        state_next   = ST_OFF;
                    end
                end
                ST_FAULT: begin
                    if (!vcore_en) begin
                        fault_next      = 1'b0;
                        fault_code_next = 3'd0;
                        state_next      = ST_OFF;
                    end
                end
                default: begin
                    // Unused encodings fall back to a fully-off OFF state.
                    p1v8_en_next    = 1'b0;
                    p3v3_en_next    = 1'b0;
                    p1v1_en_next    = 1'b0;
                    cpu_por_next    = 1'b0;
`ifdef PWR_SEQ_SOFT_POR_EN
                    io_rst_next     = 1'b0;
`endif
                    fault_next      = 1'b0;
                    fault_code_next = 3'd0;
                    state_next      = ST_OFF;
                end
            endcase
        end

        // Hard off: every enable and reset drops on the edge FAULT is entered.
        if (fault_hit) begin
            p1v8_en_next    = 1'b0;
            p3v3_en_next    = 1'b0;
            p1v1_en_next    = 1'b0;
            cpu_por_next    = 1'b0;
`ifdef PWR_SEQ_SOFT_POR_EN
            io_rst_next     = 1'b0;
`endif
            fault_next      = 1'b1;
            fault_code_next = fault_cause;
            state_next      = ST_FAULT;
        end

        // Counter restarts on any state change; a tick on that edge is dropped.
        if (state_next != state_reg)
            cnt_next = '0;
        else if (ms_pulse && (cnt_reg != '1))
            cnt_next = cnt_reg + 1'b1;
        else
            cnt_next = cnt_reg;
    end

    // State, counter and output registers with asynchronous reset to OFF.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_reg      <= ST_OFF;
            cnt_reg        <= '0;
            p1v8_en_reg    <= 1'b0;
            p3v3_en_reg    <= 1'b0;
            p1v1_en_reg    <= 1'b0;
            cpu_por_reg    <= 1'b0;
            fault_reg      <= 1'b0;
            fault_code_reg <= 3'd0;
`ifdef PWR_SEQ_SOFT_POR_EN
            io_rst_reg     <= 1'b0;
`endif
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            p1v8_en_reg    <= p1v8_en_next;
            p3v3_en_reg    <= p3v3_en_next;
            p1v1_en_reg    <= p1v1_en_next;
            cpu_por_reg    <= cpu_por_next;
            fault_reg      <= fault_next;
            fault_code_reg <= fault_code_next;
`ifdef PWR_SEQ_SOFT_POR_EN
            io_rst_reg     <= io_rst_next;
`endif
        end
    end

    assign p1v8_en    = p1v8_en_reg;
    assign p3v3_en    = p3v3_en_reg;
    assign p1v1_en    = p1v1_en_reg;
    assign cpu_por_n  = cpu_por_reg;
`ifdef PWR_SEQ_SOFT_POR_EN
    assign pcie_rst_n = io_rst_reg;
    assign phy_rst_n  = io_rst_reg;
`else
    assign pcie_rst_n = cpu_por_reg;
    assign phy_rst_n  = cpu_por_reg;
`endif
    assign seq_state  = state_reg;
    assign fault      = fault_reg;
    assign fault_code = fault_code_reg;

endmodule

// File: tb/tb_pwr_seq_ctrl.sv
// Testbench for pwr_seq_ctrl: a scoreboard of expected output snapshots,
// each with the number of ms ticks that must elapse since the previous
// output change. The monitor pops one entry per observed output change.
module tb_pwr_seq_ctrl;

    logic       sys_clk     = 1'b0;
    logic       sys_rst_n   = 1'b0;
    logic       ms_pulse    = 1'b0;
    logic       vcore_en    = 1'b0;
    logic       vcore_pwrgd = 1'b0;
    logic       p1v8_pwrgd  = 1'b0;
    logic       p3v3_pwrgd  = 1'b0;
    logic       p1v1_pwrgd  = 1'b0;
    logic       p1v8_en, p3v3_en, p1v1_en;
    logic       pcie_rst_n, phy_rst_n, cpu_por_n;
    logic [3:0] seq_state;
    logic       fault;
    logic [2:0] fault_code;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        logic [13:0] vec;
        int          pulses;   // -1: tick count not checked
    } exp_t;

    exp_t exp_q[$];

    pwr_seq_ctrl dut (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .ms_pulse    (ms_pulse),
        .vcore_en    (vcore_en),
        .vcore_pwrgd (vcore_pwrgd),
        .p1v8_pwrgd  (p1v8_pwrgd),
        .p3v3_pwrgd  (p3v3_pwrgd),
        .p1v1_pwrgd  (p1v1_pwrgd),
        .p1v8_en     (p1v8_en),
        .p3v3_en     (p3v3_en),
        .p1v1_en     (p1v1_en),
        .pcie_rst_n  (pcie_rst_n),
        .phy_rst_n   (phy_rst_n),
        .cpu_por_n   (cpu_por_n),
        .seq_state   (seq_state),
        .fault       (fault),
        .fault_code  (fault_code)
    );

    // 50 MHz clock.
    always #10 sys_clk = ~sys_clk;

    // ms tick every 4 clocks, driven away from the active edge.
    int div = 0;
    always @(negedge sys_clk) begin
        div      = (div == 3) ? 0 : div + 1;
        ms_pulse = (div == 0);
    end

    // Running count of ticks the DUT has sampled.
    int pulse_total = 0;
    always @(posedge sys_clk) begin
        if (ms_pulse)
            pulse_total = pulse_total + 1;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        if (obs !== exp) begin
            errors = errors + 1;
            $display("FAIL %s observed=0x%0h required=0x%0h", tag, obs, exp);
        end
    endtask

    // {state, p1v8/p3v3/p1v1 enables, pcie/phy/cpu resets, fault, code}
    function automatic logic [13:0] mk(input logic [3:0] st, input logic [2:0] en,
                                       input logic [2:0] rst, input logic flt,
                                       input logic [2:0] code);
        return {st, en, rst, flt, code};
    endfunction

    function automatic logic [13:0] get_vec();
        return {seq_state, p1v8_en, p3v3_en, p1v1_en, pcie_rst_n, phy_rst_n,
                cpu_por_n, fault, fault_code};
    endfunction

    task automatic expect_out(input string tag, input logic [13:0] v, input int p);
        exp_t e;
        e.tag    = tag;
        e.vec    = v;
        e.pulses = p;
        exp_q.push_back(e);
    endtask

    // Monitor: one line per output transaction, compared against the scoreboard.
    logic [13:0] last_vec = '0;
    logic [13:0] cur_vec;
    int          pulse_mark = 0;
    exp_t        pop_e;
    always @(negedge sys_clk) begin
        cur_vec = get_vec();
        if (cur_vec !== last_vec) begin
            $display("[%0t] state=%0d en=%b rst=%b fault=%b code=%0d ticks=%0d",
                     $time, cur_vec[13:10], cur_vec[9:7], cur_vec[6:4],
                     cur_vec[3], cur_vec[2:0], pulse_total - pulse_mark);
            if (exp_q.size() == 0) begin
                check_val("unexpected_change", cur_vec, last_vec);
            end else begin
                pop_e = exp_q.pop_front();
                check_val(pop_e.tag, cur_vec, pop_e.vec);
                if (pop_e.pulses >= 0)
                    check_val({pop_e.tag, "_ticks"}, pulse_total - pulse_mark, pop_e.pulses);
            end
            last_vec   = cur_vec;
            pulse_mark = pulse_total;
        end
    end

    task automatic drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge sys_clk);
            n++;
        end
        check_val("scoreboard_drained", exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic wait_pulses(input int n);
        int k = 0;
        while (k < n) begin
            @(posedge sys_clk);
            if (ms_pulse) k++;
        end
        @(negedge sys_clk);
    endtask

    // Power-up with each power-good returned 2 ms after its enable.
    // hold_3v3 leaves the sequence waiting in WAIT_3V3.
    task automatic power_up(input bit hold_3v3);
        p1v8_pwrgd = 1'b0;
        p3v3_pwrgd = 1'b0;
        p1v1_pwrgd = 1'b0;
        expect_out("vcore_dly", mk(4'd1, 3'b000, 3'b000, 1'b0, 3'd0), -1);
        expect_out("p1v8_en",   mk(4'd2, 3'b100, 3'b000, 1'b0, 3'd0), 6);
        vcore_en    = 1'b1;
        vcore_pwrgd = 1'b1;
        drain(100);
        wait_pulses(2);
        expect_out("dly_1v8", mk(4'd3, 3'b100, 3'b000, 1'b0, 3'd0), -1);
        expect_out("p3v3_en", mk(4'd4, 3'b110, 3'b000, 1'b0, 3'd0), 6);
        p1v8_pwrgd = 1'b1;
        drain(100);
        if (!hold_3v3) begin
            wait_pulses(2);
            expect_out("dly_3v3", mk(4'd5, 3'b110, 3'b000, 1'b0, 3'd0), -1);
            expect_out("p1v1_en", mk(4'd6, 3'b111, 3'b000, 1'b0, 3'd0), 6);
            p3v3_pwrgd = 1'b1;
            drain(100);
            wait_pulses(2);
            expect_out("rst_dly", mk(4'd7, 3'b111, 3'b000, 1'b0, 3'd0), -1);
`ifdef PWR_SEQ_SOFT_POR_EN
            expect_out("io_rst_release", mk(4'd7, 3'b111, 3'b110, 1'b0, 3'd0), 10);
            expect_out("por_release",    mk(4'd8, 3'b111, 3'b111, 1'b0, 3'd0), 390);
`else
            expect_out("por_release",    mk(4'd8, 3'b111, 3'b111, 1'b0, 3'd0), 400);
`endif
            p1v1_pwrgd = 1'b1;
            drain(2000);
        end
    endtask

    initial begin
        #5;
        check_val("reset_state", get_vec(), 14'd0);
        repeat (3) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        repeat (2) @(negedge sys_clk);
        check_val("idle_after_reset", get_vec(), 14'd0);

        // Normal power-up to ON.
        power_up(1'b0);

        // One-clock P1V8 power-good glitch in ON: hard fault, sticky.
        expect_out("pg_loss_fault", mk(4'd15, 3'b000, 3'b000, 1'b1, 3'd4), -1);
        p1v8_pwrgd = 1'b0;
        @(negedge sys_clk);
        p1v8_pwrgd = 1'b1;
        drain(10);
        wait_pulses(5);
        check_val("fault_sticky", get_vec(), mk(4'd15, 3'b000, 3'b000, 1'b1, 3'd4));
        expect_out("fault_clear", mk(4'd0, 3'b000, 3'b000, 1'b0, 3'd0), -1);
        vcore_en = 1'b0;
        drain(10);

        // Graceful shutdown from ON; re-request and PG loss ignored meanwhile.
        power_up(1'b0);
        expect_out("shdn_3v3", mk(4'd9, 3'b110, 3'b000, 1'b0, 3'd0), -1);
        vcore_en = 1'b0;
        drain(10);
        vcore_en   = 1'b1;
        p1v1_pwrgd = 1'b0;
        p3v3_pwrgd = 1'b0;
        expect_out("shdn_1v8",      mk(4'd10, 3'b100, 3'b000, 1'b0, 3'd0), 6);
        expect_out("shdn_off",      mk(4'd0,  3'b000, 3'b000, 1'b0, 3'd0), 6);
        expect_out("rerequest_dly", mk(4'd1,  3'b000, 3'b000, 1'b0, 3'd0), -1);
        drain(200);
        expect_out("abort_from_vcore_dly", mk(4'd0, 3'b000, 3'b000, 1'b0, 3'd0), -1);
        vcore_en = 1'b0;
        drain(10);

        // P3V3 power-good never arrives: timeout fault code 2.
        power_up(1'b1);
        expect_out("timeout_3v3", mk(4'd15, 3'b000, 3'b000, 1'b1, 3'd2), 100);
        drain(600);
        expect_out("timeout_clear", mk(4'd0, 3'b000, 3'b000, 1'b0, 3'd0), -1);
        vcore_en = 1'b0;
        drain(10);

        // VCORE power-good lost during the sequence: fault code 5.
        p1v8_pwrgd = 1'b0;
        expect_out("vcore_dly_b", mk(4'd1, 3'b000, 3'b000, 1'b0, 3'd0), -1);
        vcore_en    = 1'b1;
        vcore_pwrgd = 1'b1;
        drain(10);
        expect_out("vcore_loss", mk(4'd15, 3'b000, 3'b000, 1'b1, 3'd5), -1);
        vcore_pwrgd = 1'b0;
        drain(10);
        expect_out("vcore_loss_clear", mk(4'd0, 3'b000, 3'b000, 1'b0, 3'd0), -1);
        vcore_en = 1'b0;
        drain(10);

        // Asynchronous reset in WAIT_3V3, then restart with inputs held high.
        power_up(1'b1);
        wait_pulses(3);
        expect_out("async_reset", mk(4'd0, 3'b000, 3'b000, 1'b0, 3'd0), -1);
        #3;
        sys_rst_n = 1'b0;
        #1;
        check_val("async_rst_outputs", get_vec(), 14'd0);
        repeat (3) @(negedge sys_clk);
        expect_out("restart_vcore_dly", mk(4'd1, 3'b000, 3'b000, 1'b0, 3'd0), -1);
        expect_out("restart_p1v8_en",   mk(4'd2, 3'b100, 3'b000, 1'b0, 3'd0), 6);
        expect_out("restart_dly_1v8",   mk(4'd3, 3'b100, 3'b000, 1'b0, 3'd0), -1);
        expect_out("restart_p3v3_en",   mk(4'd4, 3'b110, 3'b000, 1'b0, 3'd0), 6);
        sys_rst_n = 1'b1;
        drain(200);
        expect_out("wait_shdn_3v3", mk(4'd9,  3'b110, 3'b000, 1'b0, 3'd0), -1);
        expect_out("wait_shdn_1v8", mk(4'd10, 3'b100, 3'b000, 1'b0, 3'd0), 6);
        expect_out("wait_shdn_off", mk(4'd0,  3'b000, 3'b000, 1'b0, 3'd0), 6);
        vcore_en = 1'b0;
        drain(200);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Backstop in case a wait above is ever left unbounded.
    initial begin
        #(20 * 40000);
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pwr_seq_ctrl.md
# pwr_seq_ctrl

- Board power-sequencing controller.
- Sits downstream of the 1 ms tick generator (`timer_1ms`) and drives the rail enables and reset releases on the NS213 BMU CPLD.
- Replaces the chain of independent `timer_n_ms` instances with a single state machine. It adds power-good timeouts, power-good-loss fault detection, orderly reverse-order shutdown, and a fault code readable by the BMC.

## Interface
Parameters:
- CNT_W, 11: width of the ms delay counter.
- DLY_STEP_MS, 6: delay from a rail's power-good to the next enable.
- DLY_RST_MS, 10: delay from P1V1 power-good to PCIe/PHY reset release.
- DLY_POR_MS, 400: delay from P1V1 power-good to CPU POR release. Must be ≥ DLY_RST_MS.
- PG_TIMEOUT_MS, 100: maximum wait for a rail's power-good after its enable.

Ports:
- sys_clk, in, 1: 50 MHz system clock. This is the single clock.
- sys_rst_n, in, 1: reset. Asynchronous assert, active-low.
- ms_pulse, in, 1: one-cycle tick every 1 ms.
- vcore_en, in, 1: sequence request (high = power on).
- vcore_pwrgd, p1v8_pwrgd, p3v3_pwrgd, p1v1_pwrgd, in, 1 each: rail power-goods. Already synchronised upstream.
- p1v8_en, p3v3_en, p1v1_en, out, 1 each: rail enables.
- pcie_rst_n, phy_rst_n, cpu_por_n, out, 1 each: active-low resets.
- seq_state, out, 4: current state encoding.
- fault, out, 1: latched fault flag.
- fault_code, out, 3: latched fault cause.

## Operation
- All outputs are registered. Reset value of every output is 0, and the state is OFF.
- A single counter `cnt` (CNT_W bits) is cleared on every state entry. It increments on `ms_pulse` and saturates at all-ones.
- A delay of N ms completes on the Nth `ms_pulse` after state entry.

States (seq_state value):
- OFF (0): all outputs low.
  - vcore_en & vcore_pwrgd → VCORE_DLY.
- VCORE_DLY (1): cnt==DLY_STEP_MS → WAIT_1V8, and set p1v8_en.
- WAIT_1V8 (2): p1v8_pwrgd → DLY_1V8.
  - cnt==PG_TIMEOUT_MS → FAULT with code 1.
- DLY_1V8 (3): cnt==DLY_STEP_MS → WAIT_3V3, and set p3v3_en.
- WAIT_3V3 (4): p3v3_pwrgd → DLY_3V3.
  - Timeout → FAULT with code 2.
- DLY_3V3 (5): cnt==DLY_STEP_MS → WAIT_1V1, and set p1v1_en.
- WAIT_1V1 (6): p1v1_pwrgd → RST_DLY.
  - Timeout → FAULT with code 3.
- RST_DLY (7):
  - cnt==DLY_RST_MS: set pcie_rst_n and phy_rst_n.
  - cnt==DLY_POR_MS: set cpu_por_n, go to ON.
- ON (8): steady state.
- SHDN_3V3 (9): cnt==DLY_STEP_MS → clear p3v3_en, go to SHDN_1V8.
- SHDN_1V8 (10): cnt==DLY_STEP_MS → clear p1v8_en, go to OFF.
- FAULT (15): all outputs low.
  - vcore_en low → OFF, and clear fault/fault_code.

Monitoring in states 1–8, in priority order:
1. vcore_en low → graceful shutdown:
   - Clear all three resets and p1v1_en on the same edge.
   - Go to SHDN_3V3. If p3v3_en is not set, go to SHDN_1V8; if p1v8_en is not set either, go to OFF.
2. vcore_pwrgd low → FAULT with code 5.
3. Power-good low on any rail whose enable is already set, excluding that rail's own WAIT state → FAULT with code 4.

Fault and shutdown rules:
- On entry to FAULT, every enable and reset drops on that same edge (hard off, no reverse order). fault is set to 1.
- FAULT is sticky while vcore_en is high.
- During SHDN_*: a vcore_en re-request is ignored until OFF is reached. Power-good loss is ignored.
- A sys_rst_n assertion mid-sequence returns all outputs to 0 and the state to OFF immediately (asynchronous).

## Timing
- Enable and reset outputs change on the sys_clk edge on which the qualifying condition is sampled. The output is visible one cycle after the condition.
- An ms_pulse coinciding with a state change is not counted in the new state.
- The power-good → next-enable delay therefore falls between DLY_STEP_MS−1 and DLY_STEP_MS ms.
- Timeout and delay compares use equality on the non-saturated counter. Every DLY/TIMEOUT parameter must be < 2^CNT_W − 1.

## Configuration
- PWR_SEQ_SOFT_POR_EN defined: pcie_rst_n and phy_rst_n are released at DLY_RST_MS, as specified above.
- PWR_SEQ_SOFT_POR_EN undefined: pcie_rst_n and phy_rst_n follow cpu_por_n exactly (same register value). The DLY_RST_MS compare is not built.

## Test plan
Benches use ms_pulse every 4 clocks and defaults unless stated.

1. Normal power-up: raise vcore_en and vcore_pwrgd; return each power-good 2 ms after its enable.
   - p1v8_en rises at pulse 6 and p3v3_en 6 pulses after p1v8_pwrgd.
   - pcie_rst_n/phy_rst_n rise 10 pulses after p1v1_pwrgd, cpu_por_n 400 pulses after it.
   - seq_state ends at 8.
2. Timeout: hold p3v3_pwrgd low.
   - At the 100th pulse after p3v3_en: all outputs go to 0, fault=1, fault_code=2, seq_state=15.
   - Dropping vcore_en returns to OFF with fault=0.
3. Power-good loss in ON: pulse p1v8_pwrgd low for 1 clock.
   - Next cycle: all outputs 0, fault_code=4.
4. Graceful off from ON: drop vcore_en.
   - Resets and p1v1_en drop at once, p3v3_en 6 pulses later, p1v8_en 6 pulses after that; seq_state=0 with no fault.
5. Reset mid-sequence: assert sys_rst_n low in WAIT_3V3.
   - All outputs 0 asynchronously. After release with inputs held high, the sequence restarts from VCORE_DLY.
6. Build without PWR_SEQ_SOFT_POR_EN and rerun scenario 1.
   - pcie_rst_n and phy_rst_n rise on the same cycle as cpu_por_n.
